// File: rtl/angular_filter_sum.sv
// 4-tap signed accumulate, round (+32 >>> 6) and clip for the intra angular predictor; 3-cycle latency, 1 sample/cycle.
// Global stall: in_ready = !out_valid || out_ready. Optional clip_count output under ANGFILT_CLIP_STAT_EN.
module angular_filter_sum #(
    parameter int BIT_DEPTH = 8,
    parameter int IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_p0,
    input  logic [15:0]          in_p1,
    input  logic [15:0]          in_p2,
    input  logic [15:0]          in_p3,
    input  logic [3:0]           in_neg,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_DEPTH-1:0] out_sample,
    output logic                 out_last,
    output logic [IDX_W-1:0]     out_idx,
    output logic [15:0]          blk_count
`ifdef ANGFILT_CLIP_STAT_EN
    ,
    output logic [15:0]          clip_count
`endif
);

    localparam logic signed [17:0] MAX_Q = 18'((1 << BIT_DEPTH) - 1);

    logic                  adv;
    logic                  hs;
    logic                  s1_vld, s2_vld, s3_vld;
    logic                  s1_last, s2_last, s3_last;
    logic signed [17:0]    s1_t01, s1_t23, s2_sum, s3_q;
    logic [BIT_DEPTH-1:0]  clip_sample;

    function automatic logic signed [17:0] signed_tap(input logic [15:0] p, input logic neg);
        logic signed [17:0] ext;
        ext = {{2{p[15]}}, p};
        return neg ? -ext : ext;
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign hs       = out_valid && out_ready;

    always_comb begin
        clip_sample = s3_q[BIT_DEPTH-1:0];
        if (s3_q < 0)
            clip_sample = '0;
        else if (s3_q > MAX_Q)
            clip_sample = '1;
    end

    // Every stage moves in lockstep with the output register; bubbles are never collapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            s3_vld     <= 1'b0;
            out_valid  <= 1'b0;
            s1_last    <= 1'b0;
            s2_last    <= 1'b0;
            s3_last    <= 1'b0;
            out_last   <= 1'b0;
            s1_t01     <= '0;
            s1_t23     <= '0;
            s2_sum     <= '0;
            s3_q       <= '0;
            out_sample <= '0;
        end else if (adv) begin
            s1_vld     <= in_valid;
            s1_last    <= in_last;
            s1_t01     <= signed_tap(in_p0, in_neg[0]) + signed_tap(in_p1, in_neg[1]);
            s1_t23     <= signed_tap(in_p2, in_neg[2]) + signed_tap(in_p3, in_neg[3]);
            s2_vld     <= s1_vld;
            s2_last    <= s1_last;
            s2_sum     <= s1_t01 + s1_t23 + 18'sd32;
            s3_vld     <= s2_vld;
            s3_last    <= s2_last;
            s3_q       <= s2_sum >>> 6;
            out_valid  <= s3_vld;
            out_last   <= s3_last;
            out_sample <= clip_sample;
        end
    end

    // Block bookkeeping is driven purely by the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx   <= '0;
            blk_count <= '0;
        end else if (hs) begin
            out_idx <= out_last ? '0 : out_idx + 1'b1;
            if (out_last)
                blk_count <= blk_count + 16'd1;
        end
    end

`ifdef ANGFILT_CLIP_STAT_EN
    logic out_clip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_clip   <= 1'b0;
            clip_count <= '0;
        end else begin
            if (adv)
                out_clip <= (s3_q < 0) || (s3_q > MAX_Q);
            if (hs && out_clip && clip_count != 16'hFFFF)
                clip_count <= clip_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_angular_filter_sum.sv
// Directed bench for angular_filter_sum: vector table for arithmetic, plus streaming, block and reset sequences.
module tb_angular_filter_sum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_p0, in_p1, in_p2, in_p3;
    logic [3:0]  in_neg;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sample;
    logic        out_last;
    logic [5:0]  out_idx;
    logic [15:0] blk_count;
`ifdef ANGFILT_CLIP_STAT_EN
    logic [15:0] clip_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] p0, p1, p2, p3;
        logic [3:0]  neg;
        logic [7:0]  exp_sample;
        logic        exp_clip;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    angular_filter_sum #(.BIT_DEPTH(8), .IDX_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p0      (in_p0),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .in_neg     (in_neg),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_last   (out_last),
        .out_idx    (out_idx),
        .blk_count  (blk_count)
`ifdef ANGFILT_CLIP_STAT_EN
        ,
        .clip_count (clip_count)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic apply_vec(input vec_t v, input int id);
        int  lat;
        bit  found;
        in_valid  = 1'b1;
        in_p0     = v.p0;
        in_p1     = v.p1;
        in_p2     = v.p2;
        in_p3     = v.p3;
        in_neg    = v.neg;
        in_last   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat   = 0;
        found = 1'b0;
        for (int k = 1; k <= 8 && !found; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                found = 1'b1;
                lat   = k;
            end
        end
        check($sformatf("vec%0d_latency", id), lat, 3);
        check($sformatf("vec%0d_sample", id), out_sample, v.exp_sample);
        check($sformatf("vec%0d_idx", id), out_idx, 0);
        check($sformatf("vec%0d_last", id), out_last, 1);
        @(posedge clk); #1;
        check($sformatf("vec%0d_bubble", id), out_valid, 0);
    endtask

    // Sample i carries p0 = 64*(i+1), so it must emerge as value i+1.
    task automatic run_stream(input int n, input int lastper, input int stall_at, input int stall_len);
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        bit   accept;
        logic [7:0] held = '0;
        while (got < n && cyc < 300) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            in_valid  = (sent < n);
            in_p0     = 16'(64 * (sent + 1));
            in_p1     = 16'd0;
            in_p2     = 16'd0;
            in_p3     = 16'd0;
            in_neg    = 4'b0000;
            in_last   = (lastper > 0) && ((sent % lastper) == lastper - 1);
            #1;
            if (cyc == stall_at && out_valid) begin
                held = out_sample;
                check("stall_in_ready_low", in_ready, 0);
            end
            if (cyc == stall_at + stall_len - 1 && out_valid)
                check("stall_sample_stable", out_sample, held);
            if (out_valid && out_ready) begin
                check($sformatf("stream_sample%0d", got), out_sample, got + 1);
                check($sformatf("stream_idx%0d", got), out_idx, (lastper > 0) ? got % lastper : got);
                check($sformatf("stream_last%0d", got), out_last,
                      ((lastper > 0) && (got % lastper == lastper - 1)) ? 1 : 0);
                got++;
            end
            accept = in_valid && in_ready;
            @(posedge clk); #1;
            if (accept)
                sent++;
            cyc++;
        end
        check("stream_count", got, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        int exp_clips;

        vecs[0]  = '{16'd0,     16'd6400,  16'd0,     16'd0,     4'b0000, 8'd100, 1'b0};
        vecs[1]  = '{16'd95,    16'd0,     16'd0,     16'd0,     4'b0000, 8'd1,   1'b0};
        vecs[2]  = '{16'd96,    16'd0,     16'd0,     16'd0,     4'b0000, 8'd2,   1'b0};
        vecs[3]  = '{16'd31,    16'd0,     16'd0,     16'd0,     4'b0000, 8'd0,   1'b0};
        vecs[4]  = '{16'd5000,  16'd0,     16'd0,     16'd0,     4'b0001, 8'd0,   1'b1};
        vecs[5]  = '{16'd16065, 16'd16065, 16'd16065, 16'd16065, 4'b0000, 8'd255, 1'b1};
        vecs[6]  = '{16'd1000,  16'd200,   16'd300,   16'd50,    4'b1010, 8'd16,  1'b0};
        vecs[7]  = '{16'd16065, 16'd223,   16'd0,     16'd0,     4'b0000, 8'd255, 1'b0};
        vecs[8]  = '{16'd16065, 16'd287,   16'd0,     16'd0,     4'b0000, 8'd255, 1'b1};
        vecs[9]  = '{16'd16065, 16'd16065, 16'd16065, 16'd16065, 4'b1111, 8'd0,   1'b1};
        vecs[10] = '{16'd100,   16'd100,   16'd0,     16'd0,     4'b0010, 8'd0,   1'b0};
        vecs[11] = '{16'd0,     16'd0,     16'd2000,  16'd8400,  4'b0100, 8'd100, 1'b0};
        vecs[12] = '{16'd33,    16'd0,     16'd0,     16'd0,     4'b0001, 8'd0,   1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_p0     = '0;
        in_p1     = '0;
        in_p2     = '0;
        in_p3     = '0;
        in_neg    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_blk_count", blk_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        exp_clips = 0;
        for (int i = 0; i < 13; i++) begin
            apply_vec(vecs[i], i);
            if (vecs[i].exp_clip)
                exp_clips++;
        end
        check("table_blk_count", blk_count, 13);
`ifdef ANGFILT_CLIP_STAT_EN
        check("table_clip_count", clip_count, exp_clips);
`endif

        // Backpressure mid-stream.
        do_reset();
        run_stream(10, 10, 5, 5);
        check("bp_blk_count", blk_count, 1);

        // Three blocks of four.
        do_reset();
        run_stream(12, 4, -1, 0);
        check("blocks_blk_count", blk_count, 3);
        check("blocks_idx_after", out_idx, 0);

        // Asynchronous reset with samples in flight.
        do_reset();
        run_stream(5, 3, -1, 0);
        check("pre_rst_blk_count", blk_count, 1);
        check("pre_rst_idx", out_idx, 2);
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_p0    = 16'd640;
        @(posedge clk); #1;
        in_p0    = 16'd704;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_idx", out_idx, 0);
        check("async_rst_blk_count", blk_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (out_valid)
                seen_valid = 1'b1;
        end
        check("post_rst_no_stale_output", seen_valid, 0);
        apply_vec(vecs[0], 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
